// File: rtl/serial_frame_deserializer_if.sv
// Bundle between a serial frame source and serial_frame_deserializer.
// master = source/consumer side, slave = deserializer side.
interface serial_frame_deserializer_if #(
   parameter int WIDTH            = 8,
   parameter int LANES            = 1,
   parameter int FRAME_SIZE_WIDTH = 8
);
   logic                        start;
   logic [FRAME_SIZE_WIDTH-1:0] framesize;
   logic [LANES-1:0]            serial;
   logic                        serial_valid;
   logic                        word_ready;
   logic [WIDTH-1:0]            parallel;
   logic                        word_valid;
   logic                        complete;
   logic                        busy;
   logic                        overrun;
   logic                        crc_error;

   modport master (
      output start, framesize, serial, serial_valid, word_ready,
      input  parallel, word_valid, complete, busy, overrun, crc_error
   );

   modport slave (
      input  start, framesize, serial, serial_valid, word_ready,
      output parallel, word_valid, complete, busy, overrun, crc_error
   );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Multi-lane frame-aware serial-to-parallel converter with a one-entry valid/ready output register.
// Optional per-lane CRC16-CCITT trailer check is enabled by defining SERIAL_CRC16_EN.
module serial_frame_deserializer #(
   parameter int WIDTH            = 8,
   parameter int LANES            = 1,
   parameter int FRAME_SIZE_WIDTH = 8
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        Enable,
   serial_frame_deserializer_if.slave  bus
);
   localparam int BCW = $clog2(WIDTH + 1);
   localparam int SW  = (WIDTH > LANES) ? (WIDTH - LANES) : 1;

`ifdef SERIAL_CRC16_EN
   typedef enum logic [1:0] {IDLE, RECEIVE, CRC, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;
`endif

   state_t                      state_reg, state_next;
   logic [BCW-1:0]              bit_cnt_reg;
   logic [FRAME_SIZE_WIDTH-1:0] word_cnt_reg;
   logic [FRAME_SIZE_WIDTH-1:0] framesize_reg;
   logic [SW-1:0]               shift_reg;
   logic [WIDTH-1:0]            shift_next;
   logic [WIDTH-1:0]            parallel_reg;
   logic                        word_valid_reg;
   logic                        overrun_reg;
   logic                        complete_reg;
   logic                        crc_error_reg;
   logic                        start_accept;
   logic                        rx_beat;
   logic                        word_full;
   logic                        last_word;

   assign start_accept = Enable && (state_reg == IDLE) && bus.start;
   assign rx_beat      = Enable && (state_reg == RECEIVE) && bus.serial_valid;
   assign word_full    = rx_beat && (bit_cnt_reg == BCW'(WIDTH - LANES));
   assign last_word    = (FRAME_SIZE_WIDTH'(word_cnt_reg + FRAME_SIZE_WIDTH'(1)) == framesize_reg);

   // Newest lane group enters at the bottom, so the first group ends up in the MSBs.
   generate
      if (LANES >= WIDTH) begin : g_shift_full
         assign shift_next = bus.serial;
      end else begin : g_shift_part
         assign shift_next = {shift_reg, bus.serial};
      end
   endgenerate

`ifdef SERIAL_CRC16_EN
   logic [3:0]       crc_cnt_reg;
   logic             crc_beat;
   logic             crc_last;
   logic [LANES-1:0] lane_mismatch;

   assign crc_beat = Enable && (state_reg == CRC) && bus.serial_valid;
   assign crc_last = crc_beat && (crc_cnt_reg == 4'd15);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_crc
         logic [15:0] calc_reg, rx_reg, calc_next, rx_next;

         assign calc_next = {calc_reg[14:0], 1'b0} ^
                            ((calc_reg[15] ^ bus.serial[gi]) ? 16'h1021 : 16'h0000);
         assign rx_next   = {rx_reg[14:0], bus.serial[gi]};
         // rx_next already holds the final trailer bit when crc_last is evaluated.
         assign lane_mismatch[gi] = (rx_next != calc_reg);

         always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
               calc_reg <= '0;
               rx_reg   <= '0;
            end else if (start_accept) begin
               calc_reg <= '0;
               rx_reg   <= '0;
            end else begin
               if (rx_beat)  calc_reg <= calc_next;
               if (crc_beat) rx_reg   <= rx_next;
            end
         end
      end
   endgenerate

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         crc_cnt_reg   <= '0;
         crc_error_reg <= 1'b0;
      end else if (start_accept) begin
         crc_cnt_reg   <= '0;
         crc_error_reg <= 1'b0;
      end else if (!Enable) begin
         crc_cnt_reg   <= '0;
      end else if (crc_beat) begin
         crc_cnt_reg <= crc_cnt_reg + 4'd1;
         if (crc_last) crc_error_reg <= |lane_mismatch;
      end
   end
`else
   assign crc_error_reg = 1'b0;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (!Enable) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (bus.start) state_next = (bus.framesize == '0) ? DONE : RECEIVE;
`ifdef SERIAL_CRC16_EN
            RECEIVE: if (word_full && last_word) state_next = CRC;
            CRC:     if (crc_last) state_next = DONE;
`else
            RECEIVE: if (word_full && last_word) state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy       = (state_reg != IDLE);
      bus.complete   = complete_reg;
      bus.parallel   = parallel_reg;
      bus.word_valid = word_valid_reg;
      bus.overrun    = overrun_reg;
      bus.crc_error  = crc_error_reg;
   end

   // complete is registered off DONE so it lands one cycle after the final word appears.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         bit_cnt_reg    <= '0;
         word_cnt_reg   <= '0;
         framesize_reg  <= '0;
         shift_reg      <= '0;
         parallel_reg   <= '0;
         word_valid_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         complete_reg   <= 1'b0;
      end else begin
         complete_reg <= Enable && (state_reg == DONE);
         if (!Enable) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            word_valid_reg <= 1'b0;
         end else begin
            if (start_accept) begin
               framesize_reg <= bus.framesize;
               bit_cnt_reg   <= '0;
               word_cnt_reg  <= '0;
               overrun_reg   <= 1'b0;
            end else if (rx_beat) begin
               shift_reg <= shift_next[SW-1:0];
               if (word_full) begin
                  bit_cnt_reg  <= '0;
                  word_cnt_reg <= word_cnt_reg + FRAME_SIZE_WIDTH'(1);
               end else begin
                  bit_cnt_reg <= bit_cnt_reg + BCW'(LANES);
               end
            end

            if (word_full) begin
               parallel_reg   <= shift_next;
               word_valid_reg <= 1'b1;
               if (word_valid_reg && !bus.word_ready) overrun_reg <= 1'b1;
            end else if (word_valid_reg && bus.word_ready) begin
               word_valid_reg <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench: one 1-lane and one 4-lane deserializer, directed plus $urandom frames.
// Expected words/CRCs come from frame_words and a long-division CRC model; honours SERIAL_CRC16_EN.
module tb_serial_frame_deserializer;
   logic Clock = 1'b0;
   logic Reset;
   logic Enable;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] frame_words [0:15];

   serial_frame_deserializer_if #(.WIDTH(8), .LANES(1), .FRAME_SIZE_WIDTH(8)) b1 ();
   serial_frame_deserializer_if #(.WIDTH(8), .LANES(4), .FRAME_SIZE_WIDTH(8)) b4 ();

   serial_frame_deserializer #(.WIDTH(8), .LANES(1), .FRAME_SIZE_WIDTH(8)) u1 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .bus(b1));
   serial_frame_deserializer #(.WIDTH(8), .LANES(4), .FRAME_SIZE_WIDTH(8)) u4 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .bus(b4));

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CRC16-CCITT, init 0: remainder of (lane bit stream followed by 16 zeros) mod 0x11021.
   function automatic logic [15:0] crc_lane(input int lanes, input int lane, input int n);
      logic [16:0] rem;
      logic [7:0]  wd;
      logic        b;
      int          g;
      rem = '0;
      g   = 8 / lanes;
      for (int k = 0; k < n * g + 16; k++) begin
         if (k < n * g) begin
            wd = frame_words[4'(k / g)];
            b  = wd[3'((g - 1 - (k % g)) * lanes + lane)];
         end else begin
            b = 1'b0;
         end
         rem = {rem[15:0], b};
         if (rem[16]) rem = rem ^ 17'h11021;
      end
      return rem[15:0];
   endfunction

   task automatic run1(input int n, input int gap, input logic rdy, input logic flip,
                       input int restart_at);
      logic [7:0] wd;
      logic       exp_ce;
`ifdef SERIAL_CRC16_EN
      logic [15:0] crc;
`endif
      exp_ce = 1'b0;
      $display("tx lanes=1 framesize=%0d gap=%0d ready=%0b crcflip=%0b w0=%02h w1=%02h",
               n, gap, rdy, flip, frame_words[0], frame_words[1]);
      b1.word_ready = rdy;
      b1.framesize  = 8'(n);
      b1.start      = 1'b1;
      step();
      b1.start = 1'b0;
      chk("busy_rise", 32'(b1.busy), 32'd1);
      chk("overrun_clear", 32'(b1.overrun), 32'd0);
      for (int w = 0; w < n; w++) begin
         wd = frame_words[4'(w)];
         for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
               for (int g = 0; g < gap; g++) begin
                  b1.serial_valid = 1'b0;
                  b1.serial       = 1'($urandom);
                  step();
               end
            end
            b1.serial       = wd[3'(7 - j)];
            b1.serial_valid = 1'b1;
            if (w == 0 && j == restart_at) begin
               b1.start     = 1'b1;
               b1.framesize = 8'd5;
            end
            step();
            b1.start = 1'b0;
            if (rdy && j < 7) chk("word_valid_early", 32'(b1.word_valid), 32'd0);
         end
         b1.serial_valid = 1'b0;
         chk("word_valid", 32'(b1.word_valid), 32'd1);
         chk("parallel", 32'(b1.parallel), 32'(wd));
         if (!rdy) chk("overrun", 32'(b1.overrun), 32'(w > 0));
      end
`ifdef SERIAL_CRC16_EN
      if (n > 0) begin
         crc = crc_lane(1, 0, n);
         if (flip) crc[3] = ~crc[3];
         exp_ce = flip;
         for (int k = 15; k >= 0; k--) begin
            b1.serial       = crc[4'(k)];
            b1.serial_valid = 1'b1;
            step();
         end
         b1.serial_valid = 1'b0;
      end
`endif
      step();
      chk("complete", 32'(b1.complete), 32'd1);
      chk("crc_error", 32'(b1.crc_error), 32'(exp_ce));
      if (rdy) chk("word_valid_drop", 32'(b1.word_valid), 32'd0);
      else     chk("overrun_hold", 32'(b1.overrun), 32'(n > 1));
      step();
      chk("complete_one_cycle", 32'(b1.complete), 32'd0);
      chk("busy_fall", 32'(b1.busy), 32'd0);
   endtask

   task automatic run4(input int n);
      logic [7:0] wd;
`ifdef SERIAL_CRC16_EN
      logic [15:0] c4 [0:3];
`endif
      $display("tx lanes=4 framesize=%0d w0=%02h", n, frame_words[0]);
      b4.word_ready = 1'b1;
      b4.framesize  = 8'(n);
      b4.start      = 1'b1;
      step();
      b4.start = 1'b0;
      chk("l4_busy_rise", 32'(b4.busy), 32'd1);
      for (int w = 0; w < n; w++) begin
         wd = frame_words[4'(w)];
         for (int j = 0; j < 2; j++) begin
            b4.serial       = (j == 0) ? wd[7:4] : wd[3:0];
            b4.serial_valid = 1'b1;
            step();
         end
         b4.serial_valid = 1'b0;
         chk("l4_word_valid", 32'(b4.word_valid), 32'd1);
         chk("l4_parallel", 32'(b4.parallel), 32'(wd));
      end
`ifdef SERIAL_CRC16_EN
      for (int l = 0; l < 4; l++) c4[2'(l)] = crc_lane(4, l, n);
      for (int k = 15; k >= 0; k--) begin
         b4.serial = {c4[3][4'(k)], c4[2][4'(k)], c4[1][4'(k)], c4[0][4'(k)]};
         b4.serial_valid = 1'b1;
         step();
      end
      b4.serial_valid = 1'b0;
`endif
      step();
      chk("l4_complete", 32'(b4.complete), 32'd1);
      chk("l4_crc_error", 32'(b4.crc_error), 32'd0);
      chk("l4_overrun", 32'(b4.overrun), 32'd0);
      step();
      chk("l4_busy_fall", 32'(b4.busy), 32'd0);
   endtask

   initial begin
      Reset  = 1'b1;
      Enable = 1'b1;
      b1.start = 1'b0; b1.framesize = '0; b1.serial = '0; b1.serial_valid = 1'b0; b1.word_ready = 1'b1;
      b4.start = 1'b0; b4.framesize = '0; b4.serial = '0; b4.serial_valid = 1'b0; b4.word_ready = 1'b1;
      step();
      step();
      chk("rst_parallel", 32'(b1.parallel), 32'd0);
      chk("rst_word_valid", 32'(b1.word_valid), 32'd0);
      chk("rst_complete", 32'(b1.complete), 32'd0);
      chk("rst_busy", 32'(b1.busy), 32'd0);
      chk("rst_overrun", 32'(b1.overrun), 32'd0);
      chk("rst_crc_error", 32'(b1.crc_error), 32'd0);
      chk("rst_l4_parallel", 32'(b4.parallel), 32'd0);
      Reset = 1'b0;
      step();

      frame_words[0] = 8'hA5; frame_words[1] = 8'h3C;
      run1(2, 0, 1'b1, 1'b0, -1);

      frame_words[0] = 8'hD2;
      run4(1);

      frame_words[0] = 8'hA5; frame_words[1] = 8'h3C;
      run1(2, 0, 1'b0, 1'b0, -1);
      run1(2, 3, 1'b1, 1'b0, -1);
      run1(0, 0, 1'b1, 1'b0, -1);

      frame_words[0] = 8'($urandom);
      run1(1, 0, 1'b1, 1'b0, 3);

      // Enable drop with one word pending and five bits of the next one shifted in.
      $display("tx lanes=1 enable drop after 8+5 bits");
      b1.word_ready = 1'b0;
      b1.framesize  = 8'd2;
      b1.start      = 1'b1;
      step();
      b1.start = 1'b0;
      for (int j = 0; j < 13; j++) begin
         b1.serial       = 1'($urandom);
         b1.serial_valid = 1'b1;
         step();
         if (j == 7) chk("en_pending_word", 32'(b1.word_valid), 32'd1);
      end
      b1.serial_valid = 1'b0;
      Enable = 1'b0;
      step();
      chk("en_busy_low", 32'(b1.busy), 32'd0);
      chk("en_word_valid_low", 32'(b1.word_valid), 32'd0);
      chk("en_overrun_hold", 32'(b1.overrun), 32'd0);
      Enable = 1'b1;
      frame_words[0] = 8'hA5;
      run1(1, 0, 1'b1, 1'b0, -1);

      for (int it = 0; it < 6; it++) begin
         for (int w = 0; w < 4; w++) frame_words[4'(w)] = 8'($urandom);
         run1($urandom_range(1, 4), $urandom_range(0, 2), 1'b1, 1'b0, -1);
      end
      for (int it = 0; it < 3; it++) begin
         for (int w = 0; w < 3; w++) frame_words[4'(w)] = 8'($urandom);
         run4($urandom_range(1, 3));
      end

`ifdef SERIAL_CRC16_EN
      frame_words[0] = 8'hA5;
      run1(1, 0, 1'b1, 1'b1, -1);
      run1(1, 0, 1'b1, 1'b0, -1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
